// File: rtl/fp_dot_pkg.sv
// Shared types and constants for the sequential single-precision dot-product block.
package fp_dot_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7fc0_0000;

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;
endpackage

// File: rtl/fp_dot_datapath.sv
// Multiplier -> prod register -> adder -> acc register; the register between the
// two units keeps them from chaining combinationally.
module fp_dot_datapath
  import fp_dot_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [FP_W-1:0] in_a,
  input  logic [FP_W-1:0] in_b,
  input  logic            load_prod,
  input  logic            acc_en,
  input  logic            acc_clr,
  output logic [FP_W-1:0] acc
);
  logic [FP_W-1:0] mul_y, add_y, prod;

  ieee_multiplication u_mul (.a(in_a), .b(in_b), .result(mul_y));
  ieee_addition       u_add (.a(acc),  .b(prod), .result(add_y));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (load_prod) prod <= mul_y;
      if (acc_clr)     acc <= FP_ZERO;
      else if (acc_en) acc <= add_y;
    end
  end
endmodule

// File: rtl/ieee_addition.sv
// Combinational IEEE-754 single-precision add, round-to-nearest-even, subnormals
// flushed to zero; an exact cancellation yields +0.
module ieee_addition
  import fp_dot_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] result
);
  logic               sa, sb, sl, ss, g, rs, cancel;
  logic [7:0]         ea, eb, el, es, d;
  logic [22:0]        ma, mb, ml, ms;
  logic [26:0]        xl, xs, sh;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic signed [9:0]  e;
  logic [23:0]        mant;
  logic [24:0]        mr;

  always_comb begin
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    if ({ea, ma} >= {eb, mb}) begin
      {sl, el, ml} = a;
      {ss, es, ms} = b;
    end else begin
      {sl, el, ml} = b;
      {ss, es, ms} = a;
    end
    d  = el - es;
    xl = {1'b1, ml, 3'b000};
    xs = {1'b1, ms, 3'b000};
    // Alignment shift keeps everything shifted out as a single sticky bit
    if (d >= 8'd27) begin
      sh = 27'd1;
    end else begin
      sh    = xs >> d;
      sh[0] = sh[0] | (|(xs & ((27'd1 << d) - 27'd1)));
    end
    if (sl == ss) sum = {1'b0, xl} + {1'b0, sh};
    else          sum = {1'b0, xl} - {1'b0, sh};
    cancel = (sum == '0);
    e  = $signed({2'b00, el});
    lz = '0;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'sd1;
    end else begin
      for (int unsigned i = 0; i < 27; i++)
        if (sum[i]) lz = 5'(26 - i);
      sum = sum << lz;
      e   = e - $signed({5'd0, lz});
    end
    mant = sum[26:3];
    g    = sum[2];
    rs   = sum[1] | sum[0];
    mr   = {1'b0, mant} + {24'd0, g & (rs | mant[0])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end

    if ((ea == 8'hff && ma != '0) || (eb == 8'hff && mb != '0) ||
        (ea == 8'hff && eb == 8'hff && sa != sb))
      result = FP_QNAN;
    else if (ea == 8'hff)
      result = a;
    else if (eb == 8'hff)
      result = b;
    else if (ea == '0 && eb == '0)
      result = {sa & sb, 31'd0};
    else if (ea == '0)
      result = b;
    else if (eb == '0)
      result = a;
    else if (cancel)
      result = FP_ZERO;
    else if (e >= 10'sd255)
      result = {sl, 8'hff, 23'd0};
    else if (e <= 10'sd0)
      result = {sl, 31'd0};
    else
      result = {sl, e[7:0], mr[22:0]};
  end
endmodule

// File: rtl/ieee_multiplication.sv
// Combinational IEEE-754 single-precision multiply, round-to-nearest-even,
// subnormal inputs and results flushed to zero.
module ieee_multiplication
  import fp_dot_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] result
);
  logic               sa, sb, sr, g, st;
  logic [7:0]         ea, eb;
  logic [22:0]        ma, mb, m;
  logic [47:0]        p;
  logic signed [9:0]  e;
  logic [23:0]        mr;

  always_comb begin
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    sr = sa ^ sb;
    p  = {1'b1, ma} * {1'b1, mb};
    e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + {23'd0, g & (st | m[0])};
    // A rounding carry out of an all-ones fraction leaves fraction zero, bumps exponent
    if (mr[23]) e = e + 10'sd1;

    if ((ea == 8'hff && ma != '0) || (eb == 8'hff && mb != '0) ||
        (ea == 8'hff && eb == '0) || (eb == 8'hff && ea == '0))
      result = FP_QNAN;
    else if (ea == 8'hff || eb == 8'hff)
      result = {sr, 8'hff, 23'd0};
    else if (ea == '0 || eb == '0)
      result = {sr, 31'd0};
    else if (e >= 10'sd255)
      result = {sr, 8'hff, 23'd0};
    else if (e <= 10'sd0)
      result = {sr, 31'd0};
    else
      result = {sr, e[7:0], mr[22:0]};
  end
endmodule

// File: rtl/fp_dot_seq.sv
// Streams element pairs through one shared multiplier and adder to form a
// single-precision dot product, with valid/ready on input and output.
module fp_dot_seq
  import fp_dot_pkg::*;
#(
  parameter  int MAX_LEN = 16,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             len_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_result
);
  state_t           state;
  logic [CNT_W-1:0] cnt, len_q, cnt_nxt;
  logic             len_ok, acc_clr, load_prod, acc_en;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == MUL);
  assign out_valid = (state == DONE);
  assign len_ok    = (len <= CNT_W'(MAX_LEN));
  assign acc_clr   = (state == IDLE) && start && len_ok;
  assign load_prod = in_ready && in_valid;
  assign acc_en    = (state == ACC);
  assign cnt_nxt   = cnt + 1'b1;

  fp_dot_datapath u_dp (
    .clk       (clk),
    .rst       (rst),
    .in_a      (in_a),
    .in_b      (in_b),
    .load_prod (load_prod),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .acc       (out_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (!len_ok) begin
            len_err <= 1'b1;
          end else if (len == '0) begin
            state <= DONE;
          end else begin
            len_q <= len;
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL:  if (in_valid) state <= ACC;
        ACC: begin
          cnt   <= cnt_nxt;
          state <= (cnt_nxt == len_q) ? DONE : MUL;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_dot_seq.sv
// Scoreboard bench for fp_dot_seq: a real-arithmetic reference feeds an expected
// queue, and an independent monitor compares each presented result.
module tb_fp_dot_seq;
  import fp_dot_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  logic             clk, rst, start, in_valid, out_ready;
  logic [CNT_W-1:0] len;
  logic             busy, len_err, in_ready, out_valid;
  logic [31:0]      in_a, in_b, out_result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] va[MAX_LEN];
  logic [31:0] vb[MAX_LEN];

  fp_dot_seq #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .len_err(len_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic real f2r(input logic [31:0] f);
    real v;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(int'(f[22:0])) / 8388608.0;
    e = int'(f[30:23]) - 127;
    if (e > 0) repeat (e) v = v * 2.0;
    else       repeat (-e) v = v / 2.0;
    return f[31] ? -v : v;
  endfunction

  // Valid only for exactly representable normal values, which is all this bench uses.
  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d;
    int          ex;
    if (v == 0.0) return 32'h0;
    d  = $realtobits(v);
    ex = int'(d[62:52]) - 896;
    return {d[63], ex[7:0], d[51:29]};
  endfunction

  function automatic real rnd_op();
    int k;
    do k = int'($urandom_range(0, 126)) - 63; while (k == 0);
    return real'(k) / 4.0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation at each output handshake and confirms the
  // result never moved while out_valid was held.
  initial begin
    logic [31:0] held, e;
    bit          held_v, unstable;
    held_v = 0;
    unstable = 0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        held_v   = 0;
        unstable = 0;
      end else begin
        if (held_v && out_result !== held) unstable = 1;
        held   = out_result;
        held_v = 1;
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%h required=none", out_result);
          end else begin
            e = exp_q.pop_front();
            check("result", out_result, e);
            check("result_stable", {31'd0, unstable}, 32'd0);
          end
          held_v   = 0;
          unstable = 0;
        end
      end
    end
  end

  task automatic run(input int l, input bit busy_start, input int hold);
    real acc;
    int  guard;
    acc = 0.0;
    for (int i = 0; i < l; i++) acc = acc + f2r(va[i]) * f2r(vb[i]);
    exp_q.push_back(r2f(acc));
    start = 1'b1;
    len   = CNT_W'(l);
    tick();
    start = 1'b0;
    if (l == 0) check("len0_valid", {31'd0, out_valid}, 32'd1);
    else        check("ready_after_start", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < l; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        tick();
      end
      if (busy_start && i == 0) begin
        start = 1'b1;
        len   = CNT_W'(MAX_LEN + 1);
        tick();
        start = 1'b0;
        check("busy_start_ignored", {30'd0, busy, len_err}, 32'd2);
      end
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
      guard = 0;
      while (!in_ready && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout actual=0 required=1");
      end
      tick();
      in_valid = 1'b0;
      in_a = $urandom;
      if (i == l - 1) begin
        check("no_valid_in_acc", {31'd0, out_valid}, 32'd0);
        tick();
        check("valid_after_acc", {31'd0, out_valid}, 32'd1);
      end
    end
    repeat (hold) tick();
    out_ready = 1'b1;
    start     = 1'b1;
    len       = CNT_W'(1);
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    #1;
    check("reset_outputs", {28'd0, busy, in_ready, out_valid, len_err}, 32'd0);
    check("reset_result", out_result, 32'h0);
    #21 rst = 1'b0;
    tick();

    va[0] = 32'h3f800000; vb[0] = 32'h40400000;
    va[1] = 32'h40000000; vb[1] = 32'h40800000;
    run(2, 0, 0);
    va[0] = 32'hc0900000; vb[0] = 32'h40000000;
    run(1, 0, 2);
    va[0] = 32'hc12a6666; vb[0] = 32'h3f800000;
    va[1] = 32'h412a6666; vb[1] = 32'h3f800000;
    run(2, 1, 5);
    run(0, 0, 1);

    start = 1'b1;
    len   = CNT_W'(MAX_LEN + 1);
    tick();
    start = 1'b0;
    check("len_err_pulse", {30'd0, len_err, busy}, 32'd2);
    tick();
    check("len_err_clear", {30'd0, len_err, busy}, 32'd0);

    // Abort a three-element run after its first accumulation begins.
    start = 1'b1;
    len   = CNT_W'(3);
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 32'h40400000;
    in_b = 32'h40400000;
    tick();
    in_valid = 1'b0;
    check("in_acc_before_reset", {30'd0, busy, in_ready}, 32'd2);
    #1 rst = 1'b1;
    #1;
    check("midrun_reset_outputs", {28'd0, busy, in_ready, out_valid, len_err}, 32'd0);
    check("midrun_reset_result", out_result, 32'h0);
    #4 rst = 1'b0;
    tick();
    va[0] = 32'h40a00000; vb[0] = 32'h3f800000;
    run(1, 0, 0);

    for (int t = 0; t < 20; t++) begin
      int l;
      l = int'($urandom_range(1, MAX_LEN));
      for (int i = 0; i < l; i++) begin
        va[i] = r2f(rnd_op());
        vb[i] = r2f(rnd_op());
      end
      run(l, (t % 4) == 0, int'($urandom_range(0, 5)));
    end

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
